// File: rtl/pdata_seq.sv
// pdata_seq: word-level command sequencer for one bit-serial MAC slice.
// Turns host commands (LOAD, MUL, MAC, LOAD_MAC, READ, CLEAR, NOP) into the
// slice's opcode / serial-rx stream. All serial timing is hidden from the host.
module pdata_seq #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [SIZE-1:0]   cmd_a,
  input  logic [SIZE-1:0]   cmd_b,
  output logic              done,
  output logic              res_valid,
  output logic [4*SIZE-1:0] res_data,
  output logic              busy,
  output logic [2:0]        dp_opcode,
  output logic              dp_rx,
  input  logic              dp_tx
);

  localparam int RW = 4*SIZE;
  localparam int LW = 2*SIZE;
  localparam int CW = $clog2(4*SIZE+1);

  // Terminal counts: the counter holds the number of shifts already issued.
  localparam logic [CW-1:0] LD_LAST = CW'(LW-1);
  localparam logic [CW-1:0] RS_LAST = CW'(RW-1);

  // Slice opcodes (codes 0/1 are never driven).
  localparam logic [2:0] OP_OUT_RES  = 3'd2;
  localparam logic [2:0] OP_LOAD     = 3'd3;
  localparam logic [2:0] OP_LOAD_RES = 3'd4;
  localparam logic [2:0] OP_MUL      = 3'd5;
  localparam logic [2:0] OP_MUL_ADD  = 3'd6;
  localparam logic [2:0] OP_NO_OP    = 3'd7;

  // Host command codes; 0 and 7 fall through to the no-activity path.
  localparam logic [2:0] CMD_LOAD     = 3'd1;
  localparam logic [2:0] CMD_MUL      = 3'd2;
  localparam logic [2:0] CMD_MAC      = 3'd3;
  localparam logic [2:0] CMD_READ     = 3'd4;
  localparam logic [2:0] CMD_CLEAR    = 3'd5;
  localparam logic [2:0] CMD_LOAD_MAC = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADSH = 3'd1,
    S_MATH   = 3'd2,
    S_READSH = 3'd3,
    S_CLRSH  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [LW-1:0]   r_ld;         // remaining operand bits, next bit at MSB
  logic            r_mac_after;  // LOAD_MAC: follow the load with MUL_ADD
  logic [RW-1:0]   r_res_shift;
  logic [RW-1:0]   r_res_data;
  logic [2:0]      r_opcode;
  logic            r_rx;
  logic            r_done;
  logic            r_res_valid;
  logic            r_ready;

  logic            w_accept;
  logic            w_recirc;

  assign w_accept  = cmd_valid && r_ready;
  assign w_recirc  = (r_state == S_READSH);

  assign cmd_ready = r_ready;
  assign busy      = ~r_ready;
  assign done      = r_done;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign dp_opcode = r_opcode;
  // During readout the result is fed straight back so the accumulator
  // rotates through a full turn and ends unchanged.
  assign dp_rx     = w_recirc ? dp_tx : r_rx;

  // Command FSM: accept, shift sequencing and all registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ld        <= '0;
      r_mac_after <= 1'b0;
      r_res_shift <= '0;
      r_res_data  <= '0;
      r_opcode    <= OP_NO_OP;
      r_rx        <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      if (w_accept) begin
        // Launch: the first working cycle's opcode/rx are set at this edge.
        r_cnt       <= '0;
        r_ld        <= {cmd_b, cmd_a} << 1;
        r_mac_after <= (cmd_op == CMD_LOAD_MAC);
        r_rx        <= 1'b0;
        r_ready     <= 1'b0;
        case (cmd_op)
          CMD_LOAD, CMD_LOAD_MAC: begin
            r_state  <= S_LOADSH;
            r_opcode <= OP_LOAD;
            r_rx     <= cmd_b[SIZE-1];
          end
          CMD_MUL: begin
            r_state  <= S_MATH;
            r_opcode <= OP_MUL;
          end
          CMD_MAC: begin
            r_state  <= S_MATH;
            r_opcode <= OP_MUL_ADD;
          end
          CMD_READ: begin
            r_state  <= S_READSH;
            r_opcode <= OP_OUT_RES;
          end
          CMD_CLEAR: begin
            r_state  <= S_CLRSH;
            r_opcode <= OP_LOAD_RES;
          end
          default: begin
            r_state  <= S_FIN;
            r_opcode <= OP_NO_OP;
            r_done   <= 1'b1;
            r_ready  <= 1'b1;
          end
        endcase
      end else begin
        case (r_state)
          S_LOADSH: begin
            if (r_cnt == LD_LAST) begin
              r_cnt <= '0;
              r_rx  <= 1'b0;
              if (r_mac_after) begin
                r_state  <= S_MATH;
                r_opcode <= OP_MUL_ADD;
              end else begin
                r_state  <= S_FIN;
                r_opcode <= OP_NO_OP;
                r_done   <= 1'b1;
                r_ready  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
              r_rx  <= r_ld[LW-1];
              r_ld  <= r_ld << 1;
            end
          end
          S_MATH: begin
            r_state  <= S_FIN;
            r_opcode <= OP_NO_OP;
            r_done   <= 1'b1;
            r_ready  <= 1'b1;
          end
          S_READSH: begin
            r_res_shift <= {r_res_shift[RW-2:0], dp_tx};
            if (r_cnt == RS_LAST) begin
              r_cnt       <= '0;
              r_res_data  <= {r_res_shift[RW-2:0], dp_tx};
              r_res_valid <= 1'b1;
              r_state     <= S_FIN;
              r_opcode    <= OP_NO_OP;
              r_done      <= 1'b1;
              r_ready     <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_CLRSH: begin
            if (r_cnt == RS_LAST) begin
              r_cnt    <= '0;
              r_state  <= S_FIN;
              r_opcode <= OP_NO_OP;
              r_done   <= 1'b1;
              r_ready  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_FIN: begin
            r_state  <= S_IDLE;
            r_opcode <= OP_NO_OP;
            r_ready  <= 1'b1;
          end
          default: begin
            r_state  <= S_IDLE;
            r_opcode <= OP_NO_OP;
            r_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pdata_seq.sv
// Bench for pdata_seq (SIZE=8): behavioural serial slice, command-level
// reference model, per-cycle compare process and directed command vectors.
module tb_pdata_seq;

  localparam int S  = 8;
  localparam int RW = 4*S;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [S-1:0]  cmd_a = '0;
  logic [S-1:0]  cmd_b = '0;
  logic          cmd_ready, done, res_valid, busy, dp_rx, dp_tx;
  logic [RW-1:0] res_data;
  logic [2:0]    dp_opcode;

  int n_cmp  = 0;
  int n_fail = 0;

  pdata_seq #(.SIZE(S)) dut (
    .clk(clk), .nRst(nRst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .done(done),
    .res_valid(res_valid), .res_data(res_data), .busy(busy),
    .dp_opcode(dp_opcode), .dp_rx(dp_rx), .dp_tx(dp_tx)
  );

  always #5 clk = ~clk;

  // Behavioural slice: operand shift chain, accumulator, serial tx.
  logic [S-1:0]  s_d1 = '0;
  logic [S-1:0]  s_d2 = '0;
  logic [RW-1:0] s_acc = '0;
  logic          r_junk = 1'b0;

  always @(negedge clk) r_junk <= 1'($urandom);
  assign dp_tx = (dp_opcode == 3'd2) ? s_acc[RW-1] : r_junk;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      s_d1 <= '0; s_d2 <= '0; s_acc <= '0;
    end else begin
      case (dp_opcode)
        3'd3: {s_d2, s_d1} <= {s_d2[S-2:0], s_d1, dp_rx};
        3'd5: s_acc <= RW'(s_d1) * RW'(s_d2);
        3'd6: s_acc <= s_acc + RW'(s_d1) * RW'(s_d2);
        3'd2, 3'd4: s_acc <= {s_acc[RW-2:0], dp_rx};
        default: ;
      endcase
    end
  end

  // Command-level reference model.
  logic          m_active = 1'b0;
  int            m_left = 0;
  int            m_lat = 0;
  logic [2:0]    m_cmd = 3'd0;
  logic [S-1:0]  m_a = '0, m_b = '0, m_d1 = '0, m_d2 = '0;
  logic [RW-1:0] m_acc = '0, m_rd = '0, m_res = '0;

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd1:       return 2*S + 1;
      3'd2, 3'd3: return 2;
      3'd4, 3'd5: return 4*S + 1;
      3'd6:       return 2*S + 2;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [2:0] exp_op(input logic [2:0] cmd, input int k);
    case (cmd)
      3'd1:    return 3'd3;
      3'd6:    return (k <= 2*S) ? 3'd3 : 3'd6;
      3'd2:    return 3'd5;
      3'd3:    return 3'd6;
      3'd4:    return 3'd2;
      3'd5:    return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic ld_bit(input int k, input logic [S-1:0] a, input logic [S-1:0] b);
    if (k >= 1 && k <= S)        return b[S-k];
    else if (k > S && k <= 2*S)  return a[2*S-k];
    else                         return 1'b0;
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_active <= 1'b0; m_left <= 0; m_lat <= 0; m_cmd <= 3'd0;
      m_d1 <= '0; m_d2 <= '0; m_acc <= '0; m_rd <= '0; m_res <= '0;
    end else if (cmd_valid && (!m_active || m_left == 0)) begin
      m_active <= 1'b1;
      m_cmd    <= cmd_op;
      m_a      <= cmd_a;
      m_b      <= cmd_b;
      m_lat    <= lat_of(cmd_op);
      m_left   <= lat_of(cmd_op) - 1;
      case (cmd_op)
        3'd1: begin m_d1 <= cmd_a; m_d2 <= cmd_b; end
        3'd2: m_acc <= RW'(m_d1) * RW'(m_d2);
        3'd3: m_acc <= m_acc + RW'(m_d1) * RW'(m_d2);
        3'd4: m_rd <= m_acc;
        3'd5: m_acc <= '0;
        3'd6: begin
          m_d1 <= cmd_a; m_d2 <= cmd_b;
          m_acc <= m_acc + RW'(cmd_a) * RW'(cmd_b);
        end
        default: ;
      endcase
    end else if (m_active) begin
      if (m_left == 0) m_active <= 1'b0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1 && m_cmd == 3'd4) m_res <= m_rd;
      end
    end
  end

  logic       e_done, e_ready, e_work;
  int         k;
  logic [2:0] e_op;
  assign e_done  = m_active && (m_left == 0);
  assign e_ready = !m_active || (m_left == 0);
  assign e_work  = m_active && (m_left != 0);
  assign k       = m_lat - m_left;
  assign e_op    = e_work ? exp_op(m_cmd, k) : 3'd7;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model.
  always @(posedge clk) begin
    #2;
    if (!nRst) begin
      chk("rst_opcode", 64'(dp_opcode), 64'd7);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_rx", 64'(dp_rx), 64'd0);
    end else begin
      chk("done", 64'(done), 64'(e_done));
      chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
      chk("busy", 64'(busy), 64'(!e_ready));
      chk("res_valid", 64'(res_valid), 64'(e_done && m_cmd == 3'd4));
      chk("res_data", 64'(res_data), 64'(m_res));
      chk("dp_opcode", 64'(dp_opcode), 64'(e_op));
      chk("opcode_legal", 64'(dp_opcode >= 3'd2), 64'd1);
      if (e_work && (m_cmd == 3'd1 || m_cmd == 3'd6) && k <= 2*S)
        chk("load_rx", 64'(dp_rx), 64'(ld_bit(k, m_a, m_b)));
      else if (e_work && m_cmd == 3'd5)
        chk("clear_rx", 64'(dp_rx), 64'd0);
      else if (e_work && m_cmd == 3'd4)
        chk("read_recirc", 64'(dp_rx), 64'(dp_tx));
    end
  end

  task automatic accept_cmd(input logic [2:0] op, input logic [S-1:0] a, input logic [S-1:0] b);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_a = S'($urandom); cmd_b = S'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run(input logic [2:0] op, input logic [S-1:0] a, input logic [S-1:0] b, output int lat);
    accept_cmd(op, a, b);
    wait_done(lat);
  endtask

  logic [2:0]   b_op [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd6, 3'd7, 3'd4};
  logic [S-1:0] b_a  [8] = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0};
  logic [S-1:0] b_b  [8] = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0};

  initial begin
    int lat, idx, dones, guard;
    logic seen, got;
    logic [RW-1:0] first_rd;

    repeat (3) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);
    chk("busy_after_rst", 64'(busy), 64'd0);

    // LOAD / MUL / READ
    run(3'd1, 8'h0F, 8'h03, lat); chk("load_latency", 64'(lat), 64'd17);
    run(3'd2, 8'h00, 8'h00, lat); chk("mul_latency", 64'(lat), 64'd2);
    run(3'd4, 8'h00, 8'h00, lat); chk("read_latency", 64'(lat), 64'd33);
    chk("read_0x2d", 64'(res_data), 64'h2D);

    // CLEAR, LOAD_MAC twice, READ twice
    run(3'd5, 8'h00, 8'h00, lat); chk("clear_latency", 64'(lat), 64'd33);
    run(3'd6, 8'hFF, 8'hFF, lat); chk("loadmac_latency", 64'(lat), 64'd18);
    run(3'd6, 8'hFF, 8'hFF, lat);
    run(3'd4, 8'h00, 8'h00, lat); chk("read_0x1fc02", 64'(res_data), 64'h1FC02);
    run(3'd4, 8'h00, 8'h00, lat); chk("reread_0x1fc02", 64'(res_data), 64'h1FC02);

    // Back-to-back with cmd_valid held high; garbage on cmd_* while busy
    @(negedge clk);
    idx = 0; dones = 0; guard = 0; got = 1'b0; first_rd = '0;
    cmd_valid = 1'b1;
    while (dones < 8 && guard < 2000) begin
      if (done) dones++;
      if (res_valid && !got) begin first_rd = res_data; got = 1'b1; end
      if (cmd_ready) begin
        if (idx < 8) begin
          cmd_op = b_op[idx]; cmd_a = b_a[idx]; cmd_b = b_b[idx];
          idx++;
        end else cmd_valid = 1'b0;
      end else begin
        cmd_op = 3'($urandom); cmd_a = S'($urandom); cmd_b = S'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 64'(idx), 64'd8);
    chk("b2b_dones", 64'(dones), 64'd8);
    chk("b2b_read1", 64'(first_rd), 64'h1E);
    chk("b2b_read2", 64'(res_data), 64'h2C);

    // Reset in the middle of a LOAD
    accept_cmd(3'd1, 8'h12, 8'h34);
    repeat (4) @(negedge clk);
    nRst = 1'b0;
    #1;
    chk("abort_opcode", 64'(dp_opcode), 64'd7);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    nRst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    run(3'd1, 8'h55, 8'hAA, lat);
    run(3'd2, 8'h00, 8'h00, lat);
    run(3'd4, 8'h00, 8'h00, lat); chk("read_0x3872", 64'(res_data), 64'h3872);

    // Reserved and NOP commands
    run(3'd7, 8'hA5, 8'h5A, lat); chk("reserved_latency", 64'(lat), 64'd1);
    run(3'd0, 8'h3C, 8'hC3, lat); chk("nop_latency", 64'(lat), 64'd1);
    run(3'd4, 8'h00, 8'h00, lat); chk("read_after_nop", 64'(res_data), 64'h3872);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
